// File: rtl/dshot_arming_controller.sv
// Arming/failsafe sequencer between the DShot frame decoder and the motor PWM stage.
// Handles arming, throttle pass-through, link timeout, direction commands and beep requests.
module dshot_arming_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 1200000,
    parameter int unsigned ARM_FRAMES     = 10,
    parameter int unsigned CMD_REPEAT     = 6,
    parameter int unsigned BEEP_CYCLES    = 4800000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_valid,
    input  logic [10:0] frame_value,
    output logic [7:0]  motor_speed,
    output logic        armed,
    output logic        failsafe,
    output logic        reversed,
    output logic        beep_active,
    output logic [2:0]  beep_tone
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned AW = $clog2(ARM_FRAMES + 1);
    localparam int unsigned RW = $clog2(CMD_REPEAT + 1);
    localparam int unsigned BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

    typedef enum logic [1:0] {
        DISARMED,
        ARMED,
        FAILSAFE
    } state_t;

    state_t          state, state_next;
    logic [AW-1:0]   arm_cnt, arm_cnt_next;
    logic [TW-1:0]   timer, timer_next;
    logic [RW-1:0]   rep_cnt, rep_cnt_next;
    logic [10:0]     last_cmd, last_cmd_next;
    logic [BW-1:0]   beep_cnt, beep_cnt_next;
    logic [7:0]      speed_next;
    logic            reversed_next;
    logic            beep_active_next;
    logic [2:0]      beep_tone_next;

    logic            is_cmd, is_dir, is_beep, same_cmd, expired, dir_fire;
    logic [7:0]      throttle_speed;

    assign is_cmd         = frame_value < 11'd48;
    assign is_dir         = frame_valid && (frame_value == 11'd7  || frame_value == 11'd8 ||
                                            frame_value == 11'd20 || frame_value == 11'd21);
    assign is_beep        = frame_valid && frame_value >= 11'd1 && frame_value <= 11'd5;
    assign same_cmd       = (last_cmd == frame_value) && (rep_cnt != '0);
    assign expired        = !frame_valid && (timer >= TW'(TIMEOUT_CYCLES - 1));
    assign throttle_speed = 8'((frame_value - 11'd48) >> 3);

    // Fires only on the edge the streak first reaches CMD_REPEAT, not on later saturated repeats.
    assign dir_fire = is_dir && (rep_cnt_next == RW'(CMD_REPEAT)) &&
                      !(same_cmd && rep_cnt == RW'(CMD_REPEAT));

    always_comb begin
        state_next       = state;
        arm_cnt_next     = arm_cnt;
        speed_next       = motor_speed;
        rep_cnt_next     = rep_cnt;
        last_cmd_next    = last_cmd;
        reversed_next    = reversed;
        beep_active_next = beep_active;
        beep_cnt_next    = beep_cnt;
        beep_tone_next   = beep_tone;

        if (frame_valid)
            timer_next = '0;
        else if (timer == TW'(TIMEOUT_CYCLES))
            timer_next = timer;
        else
            timer_next = timer + TW'(1);

        case (state)
            DISARMED: begin
                speed_next = '0;
                if (frame_valid) begin
                    if (!is_cmd) begin
                        arm_cnt_next = '0;
                    end else if (arm_cnt == AW'(ARM_FRAMES - 1)) begin
                        state_next   = ARMED;
                        arm_cnt_next = '0;
                    end else begin
                        arm_cnt_next = arm_cnt + AW'(1);
                    end
                end
            end
            ARMED: begin
                if (frame_valid) begin
                    speed_next = is_cmd ? '0 : throttle_speed;
                end else if (expired) begin
                    state_next = FAILSAFE;
                    speed_next = '0;
                end
            end
            FAILSAFE: begin
                speed_next = '0;
                if (frame_valid && is_cmd) begin
                    state_next   = DISARMED;
                    arm_cnt_next = AW'(1);
                end
            end
            default: begin
                state_next = DISARMED;
                speed_next = '0;
            end
        endcase

        if (frame_valid) begin
            last_cmd_next = frame_value;
            if (!is_dir)
                rep_cnt_next = '0;
            else if (!same_cmd)
                rep_cnt_next = RW'(1);
            else if (rep_cnt != RW'(CMD_REPEAT))
                rep_cnt_next = rep_cnt + RW'(1);
        end

        if (dir_fire && motor_speed == '0)
            reversed_next = (frame_value == 11'd8) || (frame_value == 11'd21);

        if (is_beep && state != ARMED) begin
            beep_active_next = 1'b1;
            beep_cnt_next    = BW'(BEEP_CYCLES - 1);
            beep_tone_next   = frame_value[2:0];
        end else if (beep_active) begin
            if (beep_cnt == '0) begin
                beep_active_next = 1'b0;
                beep_tone_next   = '0;
            end else begin
                beep_cnt_next = beep_cnt - BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= DISARMED;
            arm_cnt     <= '0;
            timer       <= '0;
            rep_cnt     <= '0;
            last_cmd    <= '0;
            beep_cnt    <= '0;
            motor_speed <= '0;
            reversed    <= 1'b0;
            beep_active <= 1'b0;
            beep_tone   <= '0;
        end else begin
            state       <= state_next;
            arm_cnt     <= arm_cnt_next;
            timer       <= timer_next;
            rep_cnt     <= rep_cnt_next;
            last_cmd    <= last_cmd_next;
            beep_cnt    <= beep_cnt_next;
            motor_speed <= speed_next;
            reversed    <= reversed_next;
            beep_active <= beep_active_next;
            beep_tone   <= beep_tone_next;
        end
    end

    assign armed    = (state == ARMED);
    assign failsafe = (state == FAILSAFE);

endmodule

// File: tb/tb_dshot_arming_controller.sv
// Self-checking bench for dshot_arming_controller: directed scenarios plus randomized
// frame bursts compared every cycle against a behavioural model.
module tb_dshot_arming_controller;

    localparam int unsigned T   = 40;
    localparam int unsigned ARM = 10;
    localparam int unsigned REP = 6;
    localparam int unsigned B   = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_valid = 1'b0;
    logic [10:0] frame_value = '0;
    logic [7:0]  motor_speed;
    logic        armed, failsafe, reversed, beep_active;
    logic [2:0]  beep_tone;

    int n_checks = 0;
    int n_fail   = 0;

    // model: mode 0 disarmed, 1 armed, 2 failsafe
    int m_mode, m_arm, m_idle, m_speed, m_rev, m_last, m_run, m_remain, m_tone;

    dshot_arming_controller #(
        .TIMEOUT_CYCLES(T),
        .ARM_FRAMES(ARM),
        .CMD_REPEAT(REP),
        .BEEP_CYCLES(B)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_valid(frame_valid),
        .frame_value(frame_value),
        .motor_speed(motor_speed),
        .armed(armed),
        .failsafe(failsafe),
        .reversed(reversed),
        .beep_active(beep_active),
        .beep_tone(beep_tone)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_arm = 0; m_idle = 0; m_speed = 0; m_rev = 0;
        m_last = -1; m_run = 0; m_remain = 0; m_tone = 0;
    endtask

    task automatic model_frame(input bit fv, input int v);
        bit zero, dir, bp, timeout;
        int old_mode, old_speed;
        zero = (v < 48);
        dir  = (v == 7 || v == 8 || v == 20 || v == 21);
        bp   = (v >= 1 && v <= 5);
        old_mode  = m_mode;
        old_speed = m_speed;
        timeout = (old_mode == 1) && !fv && (m_idle + 1 >= T);
        m_idle = fv ? 0 : ((m_idle < T) ? m_idle + 1 : T);

        if (fv) begin
            if (dir) begin
                m_run  = (v == m_last) ? m_run + 1 : 1;
                m_last = v;
            end else begin
                m_run  = 0;
                m_last = -1;
            end
            if (dir && m_run == REP && old_speed == 0)
                m_rev = (v == 8 || v == 21) ? 1 : 0;
        end

        if (m_remain > 0) m_remain--;
        if (m_remain == 0) m_tone = 0;
        if (fv && bp && old_mode != 1) begin
            m_remain = B;
            m_tone   = v;
        end

        case (old_mode)
            0: if (fv) begin
                if (zero) begin
                    m_arm++;
                    if (m_arm == ARM) begin
                        m_mode = 1;
                        m_arm  = 0;
                    end
                end else begin
                    m_arm = 0;
                end
            end
            1: if (fv) begin
                m_speed = zero ? 0 : (v - 48) / 8;
            end else if (timeout) begin
                m_mode  = 2;
                m_speed = 0;
            end
            default: if (fv && zero) begin
                m_mode = 0;
                m_arm  = 1;
            end
        endcase
    endtask

    task automatic compare_all();
        check("motor_speed", int'(motor_speed), m_speed);
        check("armed", int'(armed), (m_mode == 1) ? 1 : 0);
        check("failsafe", int'(failsafe), (m_mode == 2) ? 1 : 0);
        check("reversed", int'(reversed), m_rev);
        check("beep_active", int'(beep_active), (m_remain > 0) ? 1 : 0);
        check("beep_tone", int'(beep_tone), m_tone);
    endtask

    // Called at posedge+1; drives one cycle, advances the model, compares after the edge.
    task automatic step(input bit fv, input int v);
        frame_valid = fv;
        frame_value = 11'(v);
        @(posedge clk);
        model_frame(fv, v);
        #1;
        frame_valid = 1'b0;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0);
    endtask

    task automatic do_reset();
        frame_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_speed", int'(motor_speed), 0);
        check("rst_armed", int'(armed), 0);
        check("rst_failsafe", int'(failsafe), 0);
        check("rst_reversed", int'(reversed), 0);
        check("rst_beep", int'(beep_active), 0);
        check("rst_tone", int'(beep_tone), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic int rand_val();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1, 2: return 0;
            3:       return $urandom_range(1, 5);
            4: begin
                case ($urandom_range(0, 3))
                    0: return 7;
                    1: return 8;
                    2: return 20;
                    default: return 21;
                endcase
            end
            5:       return $urandom_range(0, 47);
            default: return $urandom_range(48, 2047);
        endcase
    endfunction

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Arm with 10 zero frames, then throttle 1048
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 0);
            if (i < 9) idle(1);
        end
        check("arm_after_10", int'(armed), 1);
        step(1'b1, 1048);
        check("speed_1048", int'(motor_speed), 125);

        // Full throttle, then link loss -> failsafe
        step(1'b1, 2047);
        check("speed_2047", int'(motor_speed), 249);
        idle(T - 1);
        check("fs_not_yet", int'(failsafe), 0);
        idle(1);
        check("fs_timeout", int'(failsafe), 1);
        check("fs_speed", int'(motor_speed), 0);
        step(1'b1, 2047);
        check("fs_thr_ignored", int'(motor_speed), 0);
        step(1'b1, 0);
        check("fs_to_disarmed", int'(failsafe), 0);
        check("fs_not_armed", int'(armed), 0);

        // Broken arming sequence
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 0);
        step(1'b1, 500);
        for (int i = 0; i < 9; i++) step(1'b1, 0);
        check("arm_broken", int'(armed), 0);

        // Direction streak interrupted by throttle
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 21);
        check("dir_5", int'(reversed), 0);
        step(1'b1, 1000);
        for (int i = 0; i < 5; i++) step(1'b1, 21);
        check("dir_5b", int'(reversed), 0);
        step(1'b1, 21);
        check("dir_6", int'(reversed), 1);

        // Beep hold time, then no beep while armed
        do_reset();
        step(1'b1, 3);
        check("beep_on", int'(beep_active), 1);
        check("beep_tone3", int'(beep_tone), 3);
        idle(B - 1);
        check("beep_last", int'(beep_active), 1);
        idle(1);
        check("beep_off", int'(beep_active), 0);
        for (int i = 0; i < 10; i++) step(1'b1, 0);
        step(1'b1, 3);
        check("beep_armed", int'(beep_active), 0);

        // Frame arriving in the exact expiry cycle keeps ARMED
        step(1'b1, 1048);
        idle(T - 1);
        step(1'b1, 1048);
        check("expiry_frame", int'(failsafe), 0);

        // Arming completion coincident with the 6th direction frame
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 0);
        for (int i = 0; i < 6; i++) step(1'b1, 8);
        check("coinc_armed", int'(armed), 1);
        check("coinc_rev", int'(reversed), 1);

        // Reset mid-beep and mid-streak
        do_reset();
        step(1'b1, 5);
        for (int i = 0; i < 4; i++) step(1'b1, 20);
        do_reset();
        step(1'b1, 20);
        step(1'b1, 20);
        check("streak_cleared", int'(reversed), 0);

        // Randomized bursts
        for (int b = 0; b < 400; b++) begin
            int v, len, gap;
            v   = rand_val();
            len = $urandom_range(1, 12);
            gap = $urandom_range(0, 2);
            for (int k = 0; k < len; k++) begin
                step(1'b1, v);
                idle(gap);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 60));
            if ($urandom_range(0, 39) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
